pattern_gen_multi: RTL and testbench

//  Multi-mode framebuffer pattern generator for a DISP_ROWS x DISP_COLUMNS array of MAX7219 8x8 displays.

---
 rtl/pattern_gen_multi.sv | 190 +++++++++++++++++++
 tb/tb_pattern_gen_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_multi.sv
// Multi-mode pattern generator: repaints a 1-bit framebuffer one pixel per clock and
// presents it as MAX7219 row-register command words for every 8x8 device.

package max7219_types;
   localparam logic [3:0] HDR = 4'h0;

   // Digit registers 1..8 hold display rows 0..7.
   function automatic logic [3:0] regRow(input int k);
      return 4'(k + 1);
   endfunction
endpackage

module pattern_gen_multi #(
   parameter int          DISP_ROWS    = 1,
   parameter int          DISP_COLUMNS = 1,
   parameter int          FRAME_DIV    = 1000000,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic [1:0]  i_Mode,
   input  logic        i_Hold,
   output logic        o_Busy,
   output logic        o_Frame_Done,
   output logic [15:0] o_Frame_Count,
   output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream
);
   import max7219_types::*;

   localparam int W  = DISP_COLUMNS * 8;
   localparam int H  = DISP_ROWS * 8;
   localparam int XI = $clog2(W);
   localparam int YI = $clog2(H);
   localparam int XW = XI + 1;
   localparam int YW = YI + 1;
   localparam int CW = $clog2(FRAME_DIV + 1);

   localparam logic [XW-1:0] X_LAST  = XW'(W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(H - 1);
   localparam logic [CW-1:0] CNT_END = CW'(FRAME_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2,
      WAIT   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_CLEAR   = 2'd0,
      MODE_CHECKER = 2'd1,
      MODE_RANDOM  = 2'd2,
      MODE_SCROLL  = 2'd3
   } mode_t;

   state_t                state_q, state_d;
   mode_t                 mode_q, mode_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic                  phase_q, phase_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [15:0]           count_q, count_d;
   logic [H-1:0][W-1:0]   fb_q, fb_d;

   logic [XI-1:0] xIdx;
   logic [YI-1:0] yIdx;
   logic [XW-1:0] xPlus;
   logic [XI-1:0] xNext;
   logic          lastX;
   logic          lastY;
   logic [15:0]   lfsrNext;
   logic          pixel;

   assign xIdx     = x_q[XI-1:0];
   assign yIdx     = y_q[YI-1:0];
   assign xPlus    = x_q + XW'(1);
   assign xNext    = xPlus[XI-1:0];
   assign lastX    = (x_q == X_LAST);
   assign lastY    = (y_q == Y_LAST);
   assign lfsrNext = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   // Pixel value for the current raster position; SCROLL reads the right-hand
   // neighbour, which has not yet been rewritten in this frame.
   always_comb begin
      pixel = 1'b0;
      case (mode_q)
         MODE_CHECKER: pixel = x_q[0] ^ y_q[0] ^ phase_q;
         MODE_RANDOM:  pixel = lfsr_q[0];
         MODE_SCROLL:  pixel = lastX ? lfsr_q[0] : fb_q[yIdx][xNext];
         default:      pixel = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      phase_d = phase_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      fb_d    = fb_q;

      case (state_q)
         IDLE: begin
            mode_d  = mode_t'(i_Mode);
            state_d = UPDATE;
         end
         UPDATE: begin
            fb_d[yIdx][xIdx] = pixel;
            if (mode_q == MODE_RANDOM || mode_q == MODE_SCROLL) begin
               lfsr_d = lfsrNext;
            end
            if (lastX) begin
               x_d = '0;
               if (lastY) begin
                  state_d = DONE;
               end else begin
                  y_d = y_q + YW'(1);
               end
            end else begin
               x_d = xPlus;
            end
         end
         DONE: begin
            count_d = count_q + 16'd1;
            phase_d = ~phase_q;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // The counter parks at its final value while the image is held.
            if (cnt_q == CNT_END) begin
               if (!i_Hold) begin
                  mode_d  = mode_t'(i_Mode);
                  state_d = UPDATE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= IDLE;
         mode_q  <= MODE_CLEAR;
         x_q     <= '0;
         y_q     <= '0;
         phase_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         cnt_q   <= '0;
         count_q <= '0;
         fb_q    <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         phase_q <= phase_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         fb_q    <= fb_d;
      end
   end

   // Device (r,c) row k takes its data byte from framebuffer row r*8+k, leftmost column in bit 0.
   always_comb begin
      o_MAX7219_DataStream = '0;
      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < DISP_ROWS; r++) begin
            for (int c = 0; c < DISP_COLUMNS; c++) begin
               o_MAX7219_DataStream[k][r][c] = {HDR, regRow(k), fb_q[r*8+k][c*8 +: 8]};
            end
         end
      end
   end

   assign o_Busy        = (state_q == UPDATE);
   assign o_Frame_Done  = (state_q == DONE);
   assign o_Frame_Count = count_q;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Scoreboard bench for pattern_gen_multi on a single 8x8 device with a short wait period.

module tb_pattern_gen_multi;
   localparam int FD = 4;
   localparam logic [1:0] M_CLEAR   = 2'd0;
   localparam logic [1:0] M_CHECKER = 2'd1;
   localparam logic [1:0] M_RANDOM  = 2'd2;
   localparam logic [1:0] M_SCROLL  = 2'd3;

   typedef struct packed {
      logic [15:0]     count;
      logic [7:0][7:0] rows;
   } frame_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        hold = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] frameCount;
   logic [0:7][0:0][0:0][15:0] stream;

   int tests = 0;
   int fails = 0;

   frame_t          expQ[$];
   logic [7:0][7:0] mFb;
   logic [15:0]     mLfsr;
   logic            mPhase;
   logic [15:0]     mCount;

   pattern_gen_multi #(
      .DISP_ROWS(1),
      .DISP_COLUMNS(1),
      .FRAME_DIV(FD),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .i_Clk(clk),
      .i_Rst_n(rstN),
      .i_Mode(mode),
      .i_Hold(hold),
      .o_Busy(busy),
      .o_Frame_Done(done),
      .o_Frame_Count(frameCount),
      .o_MAX7219_DataStream(stream)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, limit 500000 required");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rowWord(input logic [2:0] k, input logic [7:0] data);
      logic [3:0] reg4;
      reg4 = {1'b0, k} + 4'd1;
      return {4'h0, reg4, data};
   endfunction

   task automatic modelReset();
      mFb    = '0;
      mLfsr  = 16'hACE1;
      mPhase = 1'b0;
      mCount = 16'd0;
   endtask

   // Paint one frame in the reference model and queue the image it should produce.
   task automatic applyStimulus(input logic [1:0] m);
      logic [7:0][7:0] old;
      logic [2:0]      xi;
      logic [2:0]      yi;
      logic [2:0]      xr;
      logic            bitv;
      logic            fbBit;
      frame_t          e;
      old = mFb;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            xi = 3'(x);
            yi = 3'(y);
            xr = 3'(x + 1);
            case (m)
               M_CLEAR:   bitv = 1'b0;
               M_CHECKER: bitv = xi[0] ^ yi[0] ^ mPhase;
               M_RANDOM:  bitv = mLfsr[0];
               default:   bitv = (x < 7) ? old[yi][xr] : mLfsr[0];
            endcase
            mFb[yi][xi] = bitv;
            if (m == M_RANDOM || m == M_SCROLL) begin
               fbBit = ((mLfsr >> 0) ^ (mLfsr >> 2) ^ (mLfsr >> 3) ^ (mLfsr >> 5)) & 16'd1;
               mLfsr = (mLfsr >> 1) | (16'(fbBit) << 15);
            end
         end
      end
      mPhase  = ~mPhase;
      mCount  = mCount + 16'd1;
      e.rows  = mFb;
      e.count = mCount;
      expQ.push_back(e);
   endtask

   task automatic checkReset(input string tag);
      logic [2:0] kk;
      for (int k = 0; k < 8; k++) begin
         kk = 3'(k);
         checkOutput($sformatf("%s_word%0d", tag, k), 32'(stream[kk][0][0]), 32'(rowWord(kk, 8'h00)));
      end
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_count"}, 32'(frameCount), 32'd0);
   endtask

   task automatic waitDone(input string tag);
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
   endtask

   task automatic waitBusy(input string tag);
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1;
      end
      checkOutput({tag, "_busySeen"}, 32'(seen), 32'd1);
   endtask

   // Monitor: on every Done pulse, compare the image, the Busy length and the new frame count.
   initial begin
      int     busyRun;
      frame_t e;
      logic [2:0] kk;
      busyRun = 0;
      forever begin
         @(negedge clk);
         if (!rstN) begin
            busyRun = 0;
         end else begin
            if (busy) busyRun++;
            if (done) begin
               checkOutput("busyLength", 32'(busyRun), 32'd64);
               busyRun = 0;
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedFrame", 32'd1, 32'd0);
               end else begin
                  e = expQ.pop_front();
                  for (int k = 0; k < 8; k++) begin
                     kk = 3'(k);
                     checkOutput($sformatf("frame%0d_word%0d", e.count, k),
                                 32'(stream[kk][0][0]), 32'(rowWord(kk, e.rows[kk])));
                  end
                  @(negedge clk);
                  checkOutput($sformatf("frame%0d_count", e.count), 32'(frameCount), 32'(e.count));
               end
            end
         end
      end
   end

   // Driver
   initial begin
      int              gap;
      int              busyHits;
      int              badWords;
      logic [7:0][7:0] frozen;
      logic [2:0]      kk;

      rstN = 1'b0;
      mode = M_CHECKER;
      hold = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkReset("reset");

      applyStimulus(M_CHECKER);
      rstN = 1'b1;
      #1 checkOutput("idleBusy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("firstUpdate", 32'(busy), 32'd1);
      waitDone("f1");

      mode = M_CHECKER;
      applyStimulus(M_CHECKER);
      waitBusy("f2");
      repeat (10) @(negedge clk);
      mode = M_RANDOM;
      waitDone("f2");
      applyStimulus(M_RANDOM);
      waitDone("f3");

      mode = M_CLEAR;
      applyStimulus(M_CLEAR);
      waitDone("f4");

      mode = M_SCROLL;
      applyStimulus(M_SCROLL);
      gap = 0;
      for (int i = 0; i < 50 && !busy; i++) begin
         @(negedge clk);
         gap++;
      end
      checkOutput("doneToUpdateGap", 32'(gap), 32'(FD + 1));
      waitDone("f5");

      applyStimulus(M_SCROLL);
      waitDone("f6");

      hold   = 1'b1;
      frozen = mFb;
      mode   = M_CHECKER;
      applyStimulus(M_CHECKER);
      busyHits = 0;
      badWords = 0;
      repeat (FD + 50) begin
         @(negedge clk);
         if (busy) busyHits++;
         for (int k = 0; k < 8; k++) begin
            kk = 3'(k);
            if (stream[kk][0][0] !== rowWord(kk, frozen[kk])) badWords++;
         end
      end
      checkOutput("holdBusy", 32'(busyHits), 32'd0);
      checkOutput("holdImage", 32'(badWords), 32'd0);
      hold = 1'b0;
      @(negedge clk);
      checkOutput("holdRelease", 32'(busy), 32'd1);
      waitDone("f7");

      mode = M_RANDOM;
      waitBusy("f8");
      repeat (20) @(negedge clk);
      #2 rstN = 1'b0;
      #1 checkReset("midReset");
      modelReset();
      repeat (2) @(negedge clk);
      applyStimulus(M_RANDOM);
      rstN = 1'b1;
      #1 checkOutput("idleBusy2", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("firstUpdate2", 32'(busy), 32'd1);
      waitDone("f9");

      repeat (3) @(negedge clk);
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
